// File: rtl/ps2_byte_logger_if.sv
// Link from the PS/2 receiver into the byte logger: a ready level and the
// byte it qualifies. The receiver side drives (master), the logger listens (slave).
interface ps2_byte_logger_if #(
    parameter int DATA_W = 8
);
    logic              byte_ready;
    logic [DATA_W-1:0] byte_data;

    modport master (output byte_ready, output byte_data);
    modport slave  (input  byte_ready, input  byte_data);
endinterface

// File: rtl/ps2_byte_logger.sv
// ps2_byte_logger: capture buffer for PS/2 receiver bytes.
// Stores up to DEPTH bytes in one-shot or circular mode and shows a
// WIN_BYTES-wide window of the buffer (oldest entry in the MSBs) on hex_out.
// Optional feature macro: LOGGER_TRIGGER_EN adds trig_value/trig_mask ports
// and a WAIT_TRIG state that holds off capture until a matching byte arrives.
module ps2_byte_logger #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int WIN_BYTES   = 4,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int WSEL_W = ((DEPTH / WIN_BYTES) > 1) ? $clog2(DEPTH / WIN_BYTES) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int HEX_W  = WIN_BYTES * DATA_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    ps2_byte_logger_if.slave        rx,
    input  logic                    mode,
    input  logic                    arm,
    input  logic                    freeze,
    input  logic [WSEL_W-1:0]       win_sel,
`ifdef LOGGER_TRIGGER_EN
    input  logic [DATA_W-1:0]       trig_value,
    input  logic [DATA_W-1:0]       trig_mask,
`endif
    output logic [HEX_W-1:0]        hex_out,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    overflow,
    output logic                    capture_strobe
);

    typedef enum logic [1:0] {
        ST_CAPTURE   = 2'd0,
        ST_DONE      = 2'd1,
        ST_WAIT_TRIG = 2'd2
    } state_t;

`ifdef LOGGER_TRIGGER_EN
    localparam state_t ST_INIT = ST_WAIT_TRIG;
`else
    localparam state_t ST_INIT = ST_CAPTURE;
`endif

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   ready_prev_reg;
    logic [DATA_W-1:0]      data_reg;
    logic                   byte_edge;
    logic                   accept;
    logic                   trig_match;

    state_t                 state_reg;
    state_t                 state_next;
    logic                   wr_en;
    logic                   ovf_set;

    logic [DATA_W-1:0]      mem_reg [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [CNT_W-1:0]       fill_reg;
    logic                   wrapped_reg;
    logic                   mode_reg;
    logic                   overflow_reg;
    logic                   strobe_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   full_reg;
    logic [HEX_W-1:0]       hex_reg;
    wire  [HEX_W-1:0]       hex_next;
    logic [PTR_W-1:0]       oldest;

    // Bring the asynchronous ready level into clk and capture the byte beside the last stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_reg       <= '0;
            ready_prev_reg <= 1'b0;
            data_reg       <= '0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], rx.byte_ready};
            ready_prev_reg <= sync_reg[SYNC_STAGES-1];
            data_reg       <= rx.byte_data;
        end
    end

    assign byte_edge = sync_reg[SYNC_STAGES-1] & ~ready_prev_reg;
    // arm takes priority over a coincident byte, and freeze drops it silently
    assign accept    = byte_edge & ~freeze & ~arm;

`ifdef LOGGER_TRIGGER_EN
    assign trig_match = (((data_reg ^ trig_value) & trig_mask) == '0);
`else
    assign trig_match = 1'b0;
`endif

    // FSM state register; arm restarts capture like a reset does.
    always_ff @(posedge clk) begin
        if (!rstn || arm) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: one-shot stops after the buffer fills, a trigger match starts capture.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CAPTURE: begin
                if (wr_en && !mode_reg && fill_reg == CNT_W'(DEPTH - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_TRIG: begin
                if (wr_en) begin
                    state_next = ST_CAPTURE;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // FSM outputs: decide whether an accepted byte is stored and whether it overflows.
    always_comb begin
        wr_en   = 1'b0;
        ovf_set = 1'b0;
        case (state_reg)
            ST_CAPTURE: begin
                wr_en   = accept;
                ovf_set = accept & mode_reg & (fill_reg == CNT_W'(DEPTH));
            end
            ST_DONE: begin
                ovf_set = accept;
            end
            ST_WAIT_TRIG: begin
                wr_en = accept & trig_match;
            end
            default: begin
                wr_en   = 1'b0;
                ovf_set = 1'b0;
            end
        endcase
    end

    // Buffer storage: cleared wholesale by reset/arm, one entry written per accepted byte.
    always_ff @(posedge clk) begin
        if (!rstn || arm) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_ptr_reg] <= data_reg;
        end
    end

    // Write pointer, fill level, sticky flags and the one-cycle-late count/full view.
    always_ff @(posedge clk) begin
        if (!rstn || arm) begin
            wr_ptr_reg   <= '0;
            fill_reg     <= '0;
            wrapped_reg  <= 1'b0;
            mode_reg     <= mode;
            overflow_reg <= 1'b0;
            strobe_reg   <= 1'b0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
        end else begin
            strobe_reg <= wr_en;
            count_reg  <= fill_reg;
            full_reg   <= (fill_reg == CNT_W'(DEPTH));
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (fill_reg != CNT_W'(DEPTH)) begin
                    fill_reg <= fill_reg + CNT_W'(1);
                end
                if (wr_ptr_reg == PTR_W'(DEPTH - 1)) begin
                    wrapped_reg <= 1'b1;
                end
            end
        end
    end

    // Before the first wrap the oldest byte is entry 0; afterwards it is the next slot to overwrite.
    assign oldest = wrapped_reg ? wr_ptr_reg : '0;

    // One lane per window byte: logical index w*W+k maps to physical (oldest + w*W + k) mod DEPTH.
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        logic [PTR_W-1:0] phys;
        assign phys = oldest + PTR_W'(win_sel) * PTR_W'(WIN_BYTES) + PTR_W'(gi);
        assign hex_next[(WIN_BYTES-1-gi)*DATA_W +: DATA_W] = mem_reg[phys];
    end

    // Registered window so the display path sees a clean value one cycle after a change.
    always_ff @(posedge clk) begin
        if (!rstn || arm) begin
            hex_reg <= '0;
        end else begin
            hex_reg <= hex_next;
        end
    end

    assign hex_out        = hex_reg;
    assign count          = count_reg;
    assign full           = full_reg;
    assign overflow       = overflow_reg;
    assign capture_strobe = strobe_reg;

endmodule

// File: tb/tb_ps2_byte_logger.sv
// Self-checking bench for ps2_byte_logger: a queue-based model of the logged
// bytes is compared against the DUT every cycle, plus literal checks of the
// documented scenarios. Build with LOGGER_TRIGGER_EN to cover the trigger path.
module tb_ps2_byte_logger;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int WIN    = 4;
    localparam int SYNC   = 2;
    localparam int HEX_W  = WIN * DATA_W;
`ifdef LOGGER_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic              mode;
    logic              arm;
    logic              freeze;
    logic [0:0]        win_sel;
    logic [DATA_W-1:0] trig_value;
    logic [DATA_W-1:0] trig_mask;
    logic [HEX_W-1:0]  hex_out;
    logic [3:0]        count;
    logic              full;
    logic              overflow;
    logic              capture_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_num   = 0;

    ps2_byte_logger_if #(.DATA_W(DATA_W)) bus ();

    ps2_byte_logger #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .WIN_BYTES(WIN), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .rx(bus),
        .mode(mode),
        .arm(arm),
        .freeze(freeze),
        .win_sel(win_sel),
`ifdef LOGGER_TRIGGER_EN
        .trig_value(trig_value),
        .trig_mask(trig_mask),
`endif
        .hex_out(hex_out),
        .count(count),
        .full(full),
        .overflow(overflow),
        .capture_strobe(capture_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] mq [$];      // logged bytes, oldest first
    bit                h_rdy [$];   // ready as seen by the synchroniser, one per cycle
    logic [DATA_W-1:0] h_dat [$];
    bit                m_ovf, m_mode, m_done, m_wait;
    logic [3:0]        exp_count;
    logic              exp_full, exp_ovf, exp_strobe;
    logic [HEX_W-1:0]  exp_hex;

    function automatic logic [HEX_W-1:0] model_window(input int w);
        logic [HEX_W-1:0] res = '0;
        for (int k = 0; k < WIN; k++) begin
            int idx = w * WIN + k;
            logic [DATA_W-1:0] b = (idx < mq.size()) ? mq[idx] : '0;
            res = (res << DATA_W) | HEX_W'(b);
        end
        return res;
    endfunction

    function automatic bit hget(input int i);
        return (i >= 0 && i < h_rdy.size()) ? h_rdy[i] : 1'b0;
    endfunction

    // Model: a byte lands SYNC+1 edges after ready rises; apply the logging rules then.
    always @(posedge clk) begin : model
        int n;
        bit ev;
        logic [DATA_W-1:0] b;
        int prev_size;
        logic [HEX_W-1:0] prev_win;
        prev_size = mq.size();
        prev_win  = model_window(int'(win_sel));
        ev = 1'b0;
        b  = '0;
        if (!rstn) begin
            h_rdy.delete();
            h_dat.delete();
        end else begin
            h_rdy.push_back(bus.byte_ready);
            h_dat.push_back(bus.byte_data);
            if (h_rdy.size() > SYNC + 4) begin
                void'(h_rdy.pop_front());
                void'(h_dat.pop_front());
            end
            n  = h_rdy.size();
            ev = hget(n - 1 - SYNC) && !hget(n - 2 - SYNC);
            if (ev) b = h_dat[n - 1 - SYNC];
        end
        exp_strobe = 1'b0;
        if (!rstn || arm) begin
            mq.delete();
            m_ovf = 0; m_mode = mode; m_done = 0; m_wait = TRIG_EN;
            exp_count = '0; exp_full = 1'b0; exp_hex = '0;
        end else begin
            exp_count = 4'(prev_size);
            exp_full  = (prev_size == DEPTH);
            exp_hex   = prev_win;
            if (ev && !freeze) begin
                if (m_wait) begin
                    if (((b ^ trig_value) & trig_mask) == '0) begin
                        mq.push_back(b);
                        m_wait = 0;
                        exp_strobe = 1'b1;
                    end
                end else if (m_done) begin
                    m_ovf = 1;
                end else begin
                    if (m_mode && mq.size() == DEPTH) begin
                        void'(mq.pop_front());
                        m_ovf = 1;
                    end
                    mq.push_back(b);
                    exp_strobe = 1'b1;
                    if (!m_mode && mq.size() == DEPTH) m_done = 1;
                end
            end
        end
        exp_ovf = m_ovf;
    end

    // Compare every cycle, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        chk("count", 64'(count), 64'(exp_count));
        chk("full", 64'(full), 64'(exp_full));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        chk("capture_strobe", 64'(capture_strobe), 64'(exp_strobe));
        chk("hex_out", 64'(hex_out), 64'(exp_hex));
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int hi, input int lo, input bit arm_hit);
        @(negedge clk);
        bus.byte_data  = b;
        bus.byte_ready = 1'b1;
        for (int i = 1; i < hi + lo; i++) begin
            @(negedge clk);
            if (i == hi) bus.byte_ready = 1'b0;
            if (arm_hit) arm = (i == SYNC);
        end
        tx_num++;
        $display("tx %0d byte=%02h mode_in=%0b freeze=%0b arm_hit=%0b win=%0d count=%0d",
                 tx_num, b, mode, freeze, arm_hit, win_sel, count);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 2, SYNC + 2, 1'b0);
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    task automatic show_win(input int w);
        @(negedge clk); win_sel = 1'(w);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq1 [8] = '{8'hAA, 8'hFA, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rstn = 1'b0; mode = 1'b0; arm = 1'b0; freeze = 1'b0; win_sel = '0;
        trig_value = '0; trig_mask = '0;
        bus.byte_ready = 1'b0; bus.byte_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_hex", 64'(hex_out), 64'd0);
        rstn = 1'b1;

        // one-shot fill
        foreach (seq1[i]) send(seq1[i]);
        show_win(0);
        chk("t1_win0", 64'(hex_out), 64'hAAFA0801);
        chk("t1_full", 64'(full), 64'd1);
        chk("t1_ovf", 64'(overflow), 64'd0);
        show_win(1);
        chk("t1_win1", 64'(hex_out), 64'h02030405);

        // one-shot overflow
        send(8'h77);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_win1", 64'(hex_out), 64'h02030405);
        chk("t2_count", 64'(count), 64'd8);

        // circular wrap
        mode = 1'b1;
        pulse_arm();
        for (int i = 1; i <= 10; i++) send(8'(i));
        show_win(0);
        chk("t3_win0", 64'(hex_out), 64'h03040506);
        show_win(1);
        chk("t3_win1", 64'(hex_out), 64'h0708090A);
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);

        // arm coincident with a byte edge
        mode = 1'b0;
        show_win(0);
        pulse_arm();
        send(8'h11);
        chk("t4_pre_count", 64'(count), 64'd1);
        send_byte(8'h22, 2, SYNC + 2, 1'b1);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_hex", 64'(hex_out), 64'd0);

        // freeze
        send(8'h31);
        freeze = 1'b1;
        send(8'h32); send(8'h33); send(8'h34);
        chk("t5_count", 64'(count), 64'd1);
        chk("t5_ovf", 64'(overflow), 64'd0);
        freeze = 1'b0;
        send(8'h35);
        chk("t5_resume", 64'(count), 64'd2);
        chk("t5_win0", 64'(hex_out), 64'h31350000);

`ifdef LOGGER_TRIGGER_EN
        // trigger match
        trig_value = 8'h08; trig_mask = 8'hFF;
        pulse_arm();
        send(8'h01); send(8'h08); send(8'h09);
        chk("t6_count", 64'(count), 64'd2);
        chk("t6_win0", 64'(hex_out), 64'h08090000);
        trig_mask = '0;
`endif

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 8) begin
                mode = 1'($urandom);
                trig_value = 8'($urandom);
                trig_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                pulse_arm();
            end else if (r < 10) begin
                mode = 1'($urandom);
                @(negedge clk); rstn = 1'b0;
                @(negedge clk); rstn = 1'b1;
            end
            mode    = 1'($urandom);
            freeze  = ($urandom_range(0, 9) == 0);
            win_sel = 1'($urandom);
            send_byte(8'($urandom), int'($urandom_range(1, 4)),
                      int'($urandom_range(SYNC + 2, SYNC + 5)), ($urandom_range(0, 19) == 0));
        end
        freeze = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
